// File: rtl/bch_enc_par.sv
// Multi-cycle systematic BCH encoder: W message bits per clock into a P-bit LFSR.
// Ports: clk, rst_n (async low), in_valid/in_ready/in_data (K), out_valid/out_ready/out_data, busy.
// Macro BCH_ENC_XPARITY_EN appends an overall even-parity bit as out_data LSB.
module bch_enc_par #(
    parameter int         K        = 63,
    parameter int         P        = 12,
    parameter int         W        = 9,
    parameter logic [P:0] GEN_POLY = 13'h1539,
`ifdef BCH_ENC_XPARITY_EN
    localparam int        OW       = K + P + 1
`else
    localparam int        OW       = K + P
`endif
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [K-1:0]  in_data,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [OW-1:0] out_data,
    output logic          busy
);

    localparam int N  = K / W;
    localparam int CW = (N > 1) ? $clog2(N) : 1;

    if ((K % W) != 0 || W > K) begin : g_bad_w
        $error("bch_enc_par: W must divide K");
    end

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_HOLD
    } state_t;

    state_t         state_q;
    state_t         state_d;
    logic [K-1:0]   shreg;
    logic [K-1:0]   shreg_nxt;
    logic [K-1:0]   msg;
    logic [P-1:0]   lfsr;
    logic [P-1:0]   lfsr_nxt;
    logic [CW-1:0]  cnt;
    logic [OW-1:0]  code_nxt;
    logic           accept;
    logic           last;
    logic           run;

    assign run    = (state_q == S_RUN);
    assign accept = in_valid & in_ready;
    assign last   = (cnt == CW'(N - 1));

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE:  if (in_valid) state_d = S_RUN;
            S_RUN:   if (last) state_d = S_HOLD;
            S_HOLD:  if (out_ready) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Output logic
    always_comb begin
        in_ready  = 1'b0;
        out_valid = 1'b0;
        busy      = 1'b0;
        unique case (state_q)
            S_IDLE: in_ready = 1'b1;
            S_RUN:  busy = 1'b1;
            S_HOLD: begin
                out_valid = 1'b1;
                busy      = 1'b1;
            end
            default: in_ready = 1'b0;
        endcase
    end

    // A full-width shift would exceed the vector when W == K
    if (W < K) begin : g_shift
        assign shreg_nxt = shreg << W;
    end else begin : g_flush
        assign shreg_nxt = '0;
    end

    // W serial division steps unrolled into one cycle, MSB first
    always_comb begin
        lfsr_nxt = lfsr;
        for (int i = 0; i < W; i++) begin
            if (lfsr_nxt[P-1] ^ shreg[K-1-i]) begin
                lfsr_nxt = {lfsr_nxt[P-2:0], 1'b0} ^ GEN_POLY[P-1:0];
            end else begin
                lfsr_nxt = {lfsr_nxt[P-2:0], 1'b0};
            end
        end
    end

`ifdef BCH_ENC_XPARITY_EN
    assign code_nxt = {msg, lfsr_nxt, ^{msg, lfsr_nxt}};
`else
    assign code_nxt = {msg, lfsr_nxt};
`endif

    // Datapath
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shreg    <= '0;
            msg      <= '0;
            lfsr     <= '0;
            cnt      <= '0;
            out_data <= '0;
        end else if (accept) begin
            shreg <= in_data;
            msg   <= in_data;
            lfsr  <= '0;
            cnt   <= '0;
        end else if (run) begin
            shreg <= shreg_nxt;
            lfsr  <= lfsr_nxt;
            cnt   <= cnt + CW'(1);
            if (last) begin
                out_data <= code_nxt;
            end
        end
    end

endmodule

// File: tb/tb_bch_enc_par.sv
// Bench for bch_enc_par: directed cases plus random words on several W values,
// checked against polynomial long division.
module tb_bch_enc_par;

    localparam int         K  = 63;
    localparam int         P  = 12;
    localparam logic [P:0] G  = 13'h1539;
`ifdef BCH_ENC_XPARITY_EN
    localparam int         OW = K + P + 1;
`else
    localparam int         OW = K + P;
`endif
    localparam int         XB = OW - K - P;
    localparam int         NI = 6;

    function automatic int wof(input int g);
        case (g)
            0:       return 9;
            1:       return 1;
            2:       return 3;
            3:       return 7;
            4:       return 21;
            default: return 63;
        endcase
    endfunction

    logic           clk = 1'b0;
    logic           rst_n;
    logic           iv  [NI];
    logic [K-1:0]   id  [NI];
    logic           orr [NI];
    logic           ir  [NI];
    logic           ov  [NI];
    logic           bz  [NI];
    logic [OW-1:0]  od  [NI];

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    for (genvar g = 0; g < NI; g++) begin : g_dut
        bch_enc_par #(
            .K(K), .P(P), .W(wof(g)), .GEN_POLY(G)
        ) u_dut (
            .clk      (clk),
            .rst_n    (rst_n),
            .in_valid (iv[g]),
            .in_ready (ir[g]),
            .in_data  (id[g]),
            .out_valid(ov[g]),
            .out_ready(orr[g]),
            .out_data (od[g]),
            .busy     (bz[g])
        );
    end

    // c(x) = d(x)*x^P + (d(x)*x^P mod g(x)), by long division
    function automatic logic [OW-1:0] golden(input logic [K-1:0] d);
        logic [K+P-1:0] v;
        logic [K+P-1:0] gp;
        logic [K+P-1:0] c;
        v  = {d, {P{1'b0}}};
        gp = {{(K-1){1'b0}}, G};
        for (int i = K + P - 1; i >= P; i--) begin
            if (v[i]) v = v ^ (gp << (i - P));
        end
        c = {d, v[P-1:0]};
`ifdef BCH_ENC_XPARITY_EN
        return {c, ^c};
`else
        return c;
`endif
    endfunction

    function automatic logic [P-1:0] par_of(input logic [OW-1:0] c);
        return c[XB +: P];
    endfunction

    task automatic chk(input string tag, input logic [127:0] obs,
                       input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic timeout(input string tag);
        checks++;
        errors++;
        $error("FAIL %s observed timeout expected handshake", tag);
    endtask

    // One word through instance idx; noise drives in_valid/in_data/out_ready
    // randomly while the block is busy, which must have no effect.
    task automatic xfer(input int idx, input logic [K-1:0] d, input int stall,
                        input bit noise, output logic [OW-1:0] got,
                        output int lat);
        int n;
        got = '0;
        lat = 0;
        @(negedge clk);
        n = 0;
        while (!ir[idx] && n < 300) begin
            @(negedge clk);
            n++;
        end
        if (!ir[idx]) begin
            timeout("in_ready_wait");
            return;
        end
        iv[idx] = 1'b1;
        id[idx] = d;
        @(negedge clk);
        iv[idx] = 1'b0;
        while (!ov[idx] && lat < 300) begin
            if (noise) begin
                iv[idx]  = 1'($urandom_range(1));
                id[idx]  = K'({$urandom, $urandom});
                orr[idx] = 1'($urandom_range(1));
            end
            @(negedge clk);
            lat++;
        end
        if (!ov[idx]) begin
            timeout("out_valid_wait");
            iv[idx]  = 1'b0;
            orr[idx] = 1'b0;
            return;
        end
        got = od[idx];
        for (int s = 0; s < stall; s++) begin
            orr[idx] = 1'b0;
            iv[idx]  = noise ? 1'b1 : 1'b0;
            id[idx]  = K'({$urandom, $urandom});
            @(negedge clk);
            chk("hold_stable", 128'(od[idx]), 128'(got));
            chk("hold_valid", 128'(ov[idx]), 128'(1));
            chk("hold_in_ready", 128'(ir[idx]), 128'(0));
            chk("hold_busy", 128'(bz[idx]), 128'(1));
        end
        orr[idx] = 1'b1;
        iv[idx]  = 1'b0;
        @(negedge clk);
        chk("after_hs_valid", 128'(ov[idx]), 128'(0));
        chk("after_hs_ready", 128'(ir[idx]), 128'(1));
        orr[idx] = 1'b0;
    endtask

    initial begin
        logic [OW-1:0] got;
        logic [K-1:0]  d;
        int            lat;
        int            seen;

        rst_n = 1'b0;
        for (int i = 0; i < NI; i++) begin
            iv[i]  = 1'b0;
            id[i]  = '0;
            orr[i] = 1'b0;
        end
        repeat (3) @(negedge clk);
        chk("rst_in_ready", 128'(ir[0]), 128'(1));
        chk("rst_out_valid", 128'(ov[0]), 128'(0));
        chk("rst_busy", 128'(bz[0]), 128'(0));
        chk("rst_out_data", 128'(od[0]), 128'(0));
        rst_n = 1'b1;

        // zero word
        xfer(0, '0, 0, 1'b0, got, lat);
        chk("zero_latency", 128'(lat), 128'(7));
        chk("zero_code", 128'(got), 128'(0));

        // x^12 mod g
        d = 63'd1;
        xfer(0, d, 0, 1'b0, got, lat);
        chk("one_parity", 128'(par_of(got)), 128'(12'h539));
        chk("one_code", 128'(got), 128'(golden(d)));
`ifdef BCH_ENC_XPARITY_EN
        chk("one_xpar", 128'(got[0]), 128'(1));
`endif

        // multiple of g
        d = 63'h1539;
        xfer(0, d, 0, 1'b0, got, lat);
        chk("mult_parity", 128'(par_of(got)), 128'(0));
        chk("mult_code", 128'(got), 128'(golden(d)));

        d = '1;
        xfer(0, d, 1, 1'b0, got, lat);
        chk("ones_code", 128'(got), 128'(golden(d)));
        d = {1'b1, {(K-1){1'b0}}};
        xfer(0, d, 2, 1'b0, got, lat);
        chk("msb_code", 128'(got), 128'(golden(d)));

        // long output stall with in_valid pulsed
        d = K'({$urandom, $urandom});
        xfer(0, d, 20, 1'b1, got, lat);
        chk("stall_latency", 128'(lat), 128'(7));
        chk("stall_code", 128'(got), 128'(golden(d)));

        // reset in the middle of RUN
        @(negedge clk);
        iv[0] = 1'b1;
        id[0] = K'({$urandom, $urandom});
        @(negedge clk);
        iv[0] = 1'b0;
        repeat (2) @(negedge clk);
        chk("midrun_busy", 128'(bz[0]), 128'(1));
        rst_n = 1'b0;
        #1;
        chk("async_rst_ready", 128'(ir[0]), 128'(1));
        chk("async_rst_busy", 128'(bz[0]), 128'(0));
        chk("async_rst_data", 128'(od[0]), 128'(0));
        @(negedge clk);
        rst_n = 1'b1;
        seen = 0;
        repeat (12) begin
            @(negedge clk);
            if (ov[0]) seen++;
        end
        chk("discarded_word", 128'(seen), 128'(0));
        d = K'({$urandom, $urandom});
        xfer(0, d, 0, 1'b0, got, lat);
        chk("post_rst_latency", 128'(lat), 128'(7));
        chk("post_rst_code", 128'(got), 128'(golden(d)));

        // random words, random stalls, default width
        for (int n = 0; n < 1000; n++) begin
            d = K'({$urandom, $urandom});
            xfer(0, d, $urandom_range(3), 1'($urandom_range(1)), got, lat);
            chk("rand_w9_code", 128'(got), 128'(golden(d)));
            chk("rand_w9_latency", 128'(lat), 128'(7));
        end

        // other widths
        for (int i = 1; i < NI; i++) begin
            for (int n = 0; n < 40; n++) begin
                d = K'({$urandom, $urandom});
                xfer(i, d, $urandom_range(2), 1'($urandom_range(1)), got, lat);
                chk($sformatf("rand_w%0d_code", wof(i)),
                    128'(got), 128'(golden(d)));
                chk($sformatf("rand_w%0d_latency", wof(i)),
                    128'(lat), 128'(K / wof(i)));
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
